// File: rtl/cm_rst_ctrl.sv
// Staged reset sequencer with minimum hold, ordered stage release and sticky cause capture.
// Optional CM_RST_CTRL_ACK_EN adds the ack port and gates each stage release on the prior ack.
module cm_rst_ctrl #(
    parameter int N_REQ     = 2,
    parameter int N_OUT     = 3,
    parameter int HOLD_CYC  = 16,
    parameter int STAGE_CYC = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             cause_clr,
`ifdef CM_RST_CTRL_ACK_EN
    input  logic [N_OUT-1:0] ack,
`endif
    output logic [N_OUT-1:0] rst_o,
    output logic             done,
    output logic [N_REQ-1:0] cause
);

    localparam int MAXC = (HOLD_CYC > STAGE_CYC) ? HOLD_CYC : STAGE_CYC;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    localparam logic [CW-1:0]    HOLD_LAST  = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0]    STAGE_LAST = CW'(STAGE_CYC - 1);
    localparam logic [CW-1:0]    CNT_MAX    = CW'(MAXC);
    localparam logic [IW-1:0]    IDX_LAST   = IW'(N_OUT - 1);
    localparam logic [N_OUT-1:0] ONE        = N_OUT'(1);

    typedef enum logic [1:0] {
        ASSERT,
        RELEASE,
        RUN
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [N_OUT-1:0] rst_q, rst_d;
    logic             done_q, done_d;
    logic [N_REQ-1:0] cause_q, cause_d;

    logic             any_req;
    logic             stage_en;
    logic [CW-1:0]    cnt_inc;

    assign any_req = |req;
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

`ifdef CM_RST_CTRL_ACK_EN
    logic [IW-1:0] idx_prev;
    assign idx_prev = idx_q - IW'(1);
    // Timer for stage k+1 holds at zero until domain k acknowledges.
    assign stage_en = (idx_q == '0) || (cnt_q != '0) || ack[idx_prev];
    assign done     = done_q & ack[N_OUT-1];
`else
    assign stage_en = 1'b1;
    assign done     = done_q;
`endif

    assign rst_o = rst_q;
    assign cause = cause_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= '1;
            done_q  <= 1'b0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_d   = rst_q;
        done_d  = done_q;
        cause_d = (cause_q & ~{N_REQ{cause_clr}}) | req;

        unique case (state_q)
            ASSERT: begin
                rst_d  = '1;
                done_d = 1'b0;
                idx_d  = '0;
                if (any_req) begin
                    cnt_d = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RELEASE: begin
                if (any_req) begin
                    state_d = ASSERT;
                    rst_d   = '1;
                    done_d  = 1'b0;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (stage_en) begin
                    if (cnt_q == STAGE_LAST) begin
                        rst_d = rst_q & ~(ONE << idx_q);
                        cnt_d = '0;
                        if (idx_q == IDX_LAST) begin
                            state_d = RUN;
                            done_d  = 1'b1;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            RUN: begin
                if (any_req) begin
                    state_d = ASSERT;
                    rst_d   = '1;
                    done_d  = 1'b0;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = ASSERT;
                rst_d   = '1;
                done_d  = 1'b0;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

endmodule
